node_endpoint: RTL and testbench
================================

Name: node_endpoint

Overview:
- Traffic endpoint attached to one router local port in the mesh; it is the node-side end of the local link.
- Injection side: turns packet requests into HEAD/BODY/TAIL (or HEADTAIL) flits and sends them under per-VC on/off and allocatable flow control.
- Ejection side: sinks flits leaving the router, drives on/off and allocatable back, checks packet framing and destination, and counts traffic.
- Used as the per-node traffic generator/checker in mesh-level testbenches.

Parameters:
- MESH_SIZE_X, 2, mesh columns; destination range check.
- MESH_SIZE_Y, 3, mesh rows; destination range check.
- X_CURRENT, 0, this node's column.
- Y_CURRENT, 0, this node's row.
- MAX_PKT_LEN, 8, maximum flits per packet (>=1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  packet request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_x_dest_i  in  $clog2(MESH_SIZE_X)  destination column
- req_y_dest_i  in  $clog2(MESH_SIZE_Y)  destination row
- req_len_i  in  $clog2(MAX_PKT_LEN+1)  flit count
- data_o  out  flit_t  flit to router local input
- is_valid_o  out  1  data_o valid
- is_on_off_i  in  VC_NUM  router local-input VC may accept a flit
- is_allocatable_i  in  VC_NUM  router local-input VC free for a new packet
- data_i  in  flit_t  flit from router local output
- is_valid_i  in  1  data_i valid
- sink_stall_i  in  1  force all ejection on/off low
- is_on_off_o  out  VC_NUM  ejection VC on/off
- is_allocatable_o  out  VC_NUM  ejection VC allocatable
- pkt_sent_o  out  CNT_W  packets fully injected
- pkt_recv_o  out  CNT_W  tails/headtails received without error
- error_o  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; req_ready_o=0; is_valid_o=0; data_o=0;
  - counters=0; error_o=0; all receive in-packet flags cleared;
  - is_on_off_o='1; is_allocatable_o='1.
- Injection FSM states: IDLE, ALLOC, SEND.
  - IDLE: req_ready_o=1. On valid&ready, latch dest and len, set flit index=0, go to ALLOC.
  - Request len 0: accepted and dropped (no flits sent, pkt_sent_o not incremented), return to IDLE. Len > MAX_PKT_LEN is clamped to MAX_PKT_LEN.
  - ALLOC: pick the lowest v with is_allocatable_i[v] & is_on_off_i[v]. If none, stay in ALLOC with is_valid_o=0. If found, lock vc=v and emit the first flit in the same cycle.
    - len==1: HEADTAIL, go to IDLE, increment pkt_sent_o.
    - otherwise: HEAD, go to SEND.
  - SEND: each cycle, if is_on_off_i[vc]=1, emit the next flit on the locked vc. The last flit is TAIL; after it, go to IDLE and increment pkt_sent_o. If on/off is low, is_valid_o=0 and the flit index holds.
- Flit fields:
  - flit_label per position; vc_id = locked vc.
  - HEAD/HEADTAIL carry x_dest/y_dest.
  - BODY/TAIL payload = {pkt_seq, flit_index}; pkt_seq = pkt_sent_o low bits.
- Output timing: data_o and is_valid_o are registered, so a flit appears one cycle after the decision. Flow-control inputs are sampled on the decision cycle.
- Throughput: at most one flit per cycle. Back-to-back packets have at least 1 idle cycle (IDLE→ALLOC).
- Ejection:
  - is_on_off_o = {VC_NUM{~sink_stall_i}}, registered.
  - is_allocatable_o[v]=1 except between HEAD and TAIL on v; registered, updated the cycle after the flit.
  - Per-VC in_pkt flag: HEAD sets it, TAIL clears it, HEADTAIL leaves it 0.
- error_o is set (sticky until reset) on any of:
  - BODY/TAIL on a VC with in_pkt=0;
  - HEAD/HEADTAIL on a VC with in_pkt=1;
  - head dest != (X_CURRENT, Y_CURRENT);
  - valid flit while the previous-cycle is_on_off_o for that VC was 0.
- A TAIL or HEADTAIL that completes without error increments pkt_recv_o.
- Counters saturate at all-ones.
- Injection and ejection are independent; simultaneous events on both sides are each handled in the same cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> is_valid_o=0, req_ready_o=0, counters 0, is_on_off_o=all ones; release -> req_ready_o=1 next cycle.
- Request len=3, dest(1,2), VC0 allocatable & on -> flits HEAD, BODY, TAIL on vc 0 in 3 consecutive cycles; pkt_sent_o=1.
- Request len=4, is_allocatable_i=2'b10 -> vc_id=1. Drop is_on_off_i[1] for 2 cycles after HEAD -> exactly 2-cycle gap, payload indices continuous, TAIL last.
- Request len=1 -> single HEADTAIL. Request len=0 -> no flit, pkt_sent_o unchanged.
- Ejection: HEAD, BODY, TAIL on vc1 with dest=(X_CURRENT, Y_CURRENT) -> is_allocatable_o[1] low from HEAD+1 to TAIL+1; pkt_recv_o=1; error_o=0.
- Errors: BODY on an idle VC, HEAD to the wrong dest, or a flit during sink_stall -> each sets error_o=1 (sticky) and pkt_recv_o does not increment.

Source files
------------

// File: rtl/node_endpoint.sv
// node_endpoint: node-side end of a router local link.
// Injects request-driven packets and sinks/checks ejected flits.
package node_endpoint_pkg;
    localparam int VC_NUM = 2;
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t     flit_label;
        logic [VC_W-1:0] vc_id;
        logic [DATA_W-1:0] data;
    } flit_t;
endpackage

module node_endpoint
    import node_endpoint_pkg::*;
#(
    parameter int MESH_SIZE_X = 2,
    parameter int MESH_SIZE_Y = 3,
    parameter int X_CURRENT   = 0,
    parameter int Y_CURRENT   = 0,
    parameter int MAX_PKT_LEN = 8,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [$clog2(MESH_SIZE_X)-1:0]   req_x_dest_i,
    input  logic [$clog2(MESH_SIZE_Y)-1:0]   req_y_dest_i,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0] req_len_i,
    output flit_t                            data_o,
    output logic                             is_valid_o,
    input  logic [VC_NUM-1:0]                is_on_off_i,
    input  logic [VC_NUM-1:0]                is_allocatable_i,
    input  flit_t                            data_i,
    input  logic                             is_valid_i,
    input  logic                             sink_stall_i,
    output logic [VC_NUM-1:0]                is_on_off_o,
    output logic [VC_NUM-1:0]                is_allocatable_o,
    output logic [CNT_W-1:0]                 pkt_sent_o,
    output logic [CNT_W-1:0]                 pkt_recv_o,
    output logic                             error_o
);
    localparam int XW = $clog2(MESH_SIZE_X);
    localparam int YW = $clog2(MESH_SIZE_Y);
    localparam int LW = $clog2(MAX_PKT_LEN + 1);
    localparam int PW = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, ALLOC, SEND} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [LW-1:0]   len_q, len_d, idx_q, idx_d, len_eff;
    logic [VC_W-1:0] vc_q, vc_d, pick;
    logic            found, sent_inc, valid_d, ready_en_q;
    flit_t           flit_d;

    assign req_ready_o = ready_en_q && (state_q == IDLE);
    assign len_eff = (req_len_i > LW'(MAX_PKT_LEN)) ? LW'(MAX_PKT_LEN) : req_len_i;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        len_d    = len_q;
        idx_d    = idx_q;
        vc_d     = vc_q;
        flit_d   = '0;
        valid_d  = 1'b0;
        sent_inc = 1'b0;
        found    = 1'b0;
        pick     = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (is_allocatable_i[v] && is_on_off_i[v]) begin
                found = 1'b1;
                pick  = VC_W'(v);
            end
        end
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o && (req_len_i != '0)) begin
                    x_d     = req_x_dest_i;
                    y_d     = req_y_dest_i;
                    len_d   = len_eff;
                    idx_d   = '0;
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                if (found) begin
                    vc_d         = pick;
                    valid_d      = 1'b1;
                    flit_d.vc_id = pick;
                    flit_d.data  = {PW'(x_q), PW'(y_q)};
                    if (len_q == LW'(1)) begin
                        flit_d.flit_label = HEADTAIL;
                        sent_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        flit_d.flit_label = HEAD;
                        idx_d   = LW'(1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (is_on_off_i[vc_q]) begin
                    valid_d      = 1'b1;
                    flit_d.vc_id = vc_q;
                    flit_d.data  = {PW'(pkt_sent_o), PW'(idx_q)};
                    idx_d        = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) begin
                        flit_d.flit_label = TAIL;
                        sent_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        flit_d.flit_label = BODY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            vc_q       <= '0;
            data_o     <= '0;
            is_valid_o <= 1'b0;
            pkt_sent_o <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            vc_q       <= vc_d;
            data_o     <= flit_d;
            is_valid_o <= valid_d;
            ready_en_q <= 1'b1;
            if (sent_inc && (pkt_sent_o != '1))
                pkt_sent_o <= pkt_sent_o + CNT_W'(1);
        end
    end

    // Ejection: per-VC framing state plus a taint bit for packets that broke mid-way
    logic [VC_NUM-1:0] in_pkt_q, in_pkt_d, bad_q, bad_d, on_prev_q;
    logic [VC_W-1:0]   rx_vc;
    logic              rx_head, rx_err, recv_inc;

    assign rx_vc   = data_i.vc_id;
    assign rx_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    assign is_allocatable_o = ~in_pkt_q;

    always_comb begin
        in_pkt_d = in_pkt_q;
        bad_d    = bad_q;
        rx_err   = 1'b0;
        recv_inc = 1'b0;
        if (is_valid_i) begin
            if (!on_prev_q[rx_vc])
                rx_err = 1'b1;
            if (rx_head) begin
                if (in_pkt_q[rx_vc] ||
                    (data_i.data != {PW'(X_CURRENT), PW'(Y_CURRENT)}))
                    rx_err = 1'b1;
            end else if (!in_pkt_q[rx_vc]) begin
                rx_err = 1'b1;
            end
            unique case (data_i.flit_label)
                HEAD: begin
                    in_pkt_d[rx_vc] = 1'b1;
                    bad_d[rx_vc]    = rx_err;
                end
                BODY: bad_d[rx_vc] = bad_q[rx_vc] | rx_err;
                TAIL: begin
                    in_pkt_d[rx_vc] = 1'b0;
                    bad_d[rx_vc]    = 1'b0;
                    recv_inc        = !rx_err && !bad_q[rx_vc];
                end
                HEADTAIL: recv_inc = !rx_err;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_q    <= '0;
            bad_q       <= '0;
            on_prev_q   <= '1;
            is_on_off_o <= '1;
            pkt_recv_o  <= '0;
            error_o     <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            bad_q       <= bad_d;
            on_prev_q   <= is_on_off_o;
            is_on_off_o <= {VC_NUM{~sink_stall_i}};
            if (rx_err)
                error_o <= 1'b1;
            if (recv_inc && (pkt_recv_o != '1))
                pkt_recv_o <= pkt_recv_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_node_endpoint.sv
// tb_node_endpoint: scoreboard bench for node_endpoint.
// Randomized injection against a packet-level model, directed ejection.
module tb_node_endpoint;
    import node_endpoint_pkg::*;

    localparam int MAXL = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [0:0]        req_x_dest_i = '0;
    logic [1:0]        req_y_dest_i = '0;
    logic [3:0]        req_len_i = '0;
    flit_t             data_o;
    logic              is_valid_o;
    logic [VC_NUM-1:0] is_on_off_i = '1;
    logic [VC_NUM-1:0] is_allocatable_i = '0;
    flit_t             data_i = '0;
    logic              is_valid_i = 1'b0;
    logic              sink_stall_i = 1'b0;
    logic [VC_NUM-1:0] is_on_off_o;
    logic [VC_NUM-1:0] is_allocatable_o;
    logic [15:0]       pkt_sent_o;
    logic [15:0]       pkt_recv_o;
    logic              error_o;

    node_endpoint #(
        .MESH_SIZE_X(2), .MESH_SIZE_Y(3), .X_CURRENT(0), .Y_CURRENT(0),
        .MAX_PKT_LEN(MAXL), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_x_dest_i(req_x_dest_i), .req_y_dest_i(req_y_dest_i),
        .req_len_i(req_len_i),
        .data_o(data_o), .is_valid_o(is_valid_o),
        .is_on_off_i(is_on_off_i), .is_allocatable_i(is_allocatable_i),
        .data_i(data_i), .is_valid_i(is_valid_i),
        .sink_stall_i(sink_stall_i),
        .is_on_off_o(is_on_off_o), .is_allocatable_o(is_allocatable_o),
        .pkt_sent_o(pkt_sent_o), .pkt_recv_o(pkt_recv_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_total = 0;
    int    exp_sent = 0;
    int    cyc = 0;
    bit    rand_fc = 1'b0;
    flit_t sb_q[$];
    int    stamp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && is_valid_o) begin
            stamp_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL flit_unexpected got=%0h exp=none", data_o);
            end else begin
                chk("flit", 32'(data_o), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_fc) is_on_off_i = VC_NUM'($urandom);
        end
    end

    // Packet model: position decides the label, payload from the rules
    task automatic push_pkt(input int x, input int y, input int len,
                            input int vc);
        int l;
        flit_t f;
        l = (len > MAXL) ? MAXL : len;
        if (l == 0) return;
        for (int i = 0; i < l; i++) begin
            f.vc_id = VC_W'(vc);
            if (i == 0) begin
                f.flit_label = (l == 1) ? HEADTAIL : HEAD;
                f.data = 16'(x * 256 + y);
            end else begin
                f.flit_label = (i == l - 1) ? TAIL : BODY;
                f.data = 16'((exp_sent % 256) * 256 + i);
            end
            sb_q.push_back(f);
        end
        exp_sent++;
    endtask

    task automatic send_req(input int x, input int y, input int len,
                            input int vc);
        int k;
        is_allocatable_i = VC_NUM'(1 << vc);
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_x_dest_i = 1'(x);
        req_y_dest_i = 2'(y);
        req_len_i    = 4'(len);
        push_pkt(x, y, len, vc);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        repeat (2) @(negedge clk);
        while (!(sb_q.size() == 0 && pkt_sent_o == 16'(exp_sent)) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        chk("pkt_sent", 32'(pkt_sent_o), 32'(exp_sent));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(input flit_label_t l, input int vc,
                                 input int d);
        flit_t f;
        f.flit_label = l;
        f.vc_id = VC_W'(vc);
        f.data = 16'(d);
        return f;
    endfunction

    task automatic drive_flit(input flit_t f);
        data_i = f;
        is_valid_i = 1'b1;
        @(posedge clk);
        #1 is_valid_i = 1'b0;
    endtask

    initial begin
        repeat (5) begin
            @(posedge clk);
            #1;
            req_valid_i      = 1'($urandom);
            req_len_i        = 4'($urandom);
            is_on_off_i      = VC_NUM'($urandom);
            is_allocatable_i = VC_NUM'($urandom);
            data_i           = flit_t'($urandom);
            is_valid_i       = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_valid", 32'(is_valid_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_sent", 32'(pkt_sent_o), 32'd0);
        chk("rst_recv", 32'(pkt_recv_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_onoff", 32'(is_on_off_o), 32'h3);
        chk("rst_alloc", 32'(is_allocatable_o), 32'h3);
        req_valid_i = 1'b0;
        is_valid_i = 1'b0;
        is_on_off_i = '1;
        is_allocatable_i = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        chk("rel_ready1", 32'(req_ready_o), 32'd1);

        stamp_q.delete();
        send_req(1, 2, 3, 0);
        wait_done();
        chk("len3_count", 32'(stamp_q.size()), 32'd3);
        if (stamp_q.size() == 3) begin
            chk("len3_gap0", 32'(stamp_q[1] - stamp_q[0]), 32'd1);
            chk("len3_gap1", 32'(stamp_q[2] - stamp_q[1]), 32'd1);
        end

        stamp_q.delete();
        send_req(1, 1, 4, 1);
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!is_valid_o && k < 40);
        end
        is_on_off_i = 2'b01;
        repeat (2) @(posedge clk);
        #1 is_on_off_i = 2'b11;
        wait_done();
        chk("stall_count", 32'(stamp_q.size()), 32'd4);
        if (stamp_q.size() == 4) begin
            chk("stall_gap", 32'(stamp_q[1] - stamp_q[0]), 32'd3);
            chk("stall_b2", 32'(stamp_q[2] - stamp_q[1]), 32'd1);
            chk("stall_t", 32'(stamp_q[3] - stamp_q[2]), 32'd1);
        end

        send_req(0, 2, 1, 0);
        wait_done();
        stamp_q.delete();
        send_req(1, 0, 0, 0);
        wait_done();
        chk("len0_noflit", 32'(stamp_q.size()), 32'd0);
        send_req(0, 1, 12, 1);
        wait_done();

        rand_fc = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send_req($urandom_range(0, 1), $urandom_range(0, 2),
                     $urandom_range(0, 15), $urandom_range(0, 1));
            wait_done();
        end
        rand_fc = 1'b0;
        @(posedge clk);
        #1 is_on_off_i = '1;

        do_reset();
        chk("ej_alloc_idle", 32'(is_allocatable_o), 32'h3);
        drive_flit(mk(HEAD, 1, 0));
        chk("ej_alloc_head", 32'(is_allocatable_o), 32'h1);
        drive_flit(mk(BODY, 1, 5));
        chk("ej_alloc_body", 32'(is_allocatable_o), 32'h1);
        drive_flit(mk(TAIL, 1, 6));
        chk("ej_alloc_tail", 32'(is_allocatable_o), 32'h3);
        chk("ej_recv", 32'(pkt_recv_o), 32'd1);
        chk("ej_error", 32'(error_o), 32'd0);
        drive_flit(mk(HEADTAIL, 0, 0));
        chk("ej_recv_ht", 32'(pkt_recv_o), 32'd2);

        do_reset();
        drive_flit(mk(BODY, 0, 1));
        chk("err_body_err", 32'(error_o), 32'd1);
        chk("err_body_recv", 32'(pkt_recv_o), 32'd0);
        drive_flit(mk(HEADTAIL, 0, 0));
        chk("err_sticky", 32'(error_o), 32'd1);

        do_reset();
        drive_flit(mk(HEADTAIL, 1, 16'h0102));
        chk("err_dest_err", 32'(error_o), 32'd1);
        chk("err_dest_recv", 32'(pkt_recv_o), 32'd0);

        do_reset();
        sink_stall_i = 1'b1;
        @(posedge clk);
        #1 chk("stall_onoff", 32'(is_on_off_o), 32'd0);
        @(posedge clk);
        #1 drive_flit(mk(HEADTAIL, 0, 0));
        chk("err_stall_err", 32'(error_o), 32'd1);
        chk("err_stall_recv", 32'(pkt_recv_o), 32'd0);
        sink_stall_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
